fp_wrb_arbiter: RTL

FP_WRB_ARBITER -- requirements
Module: fp_wrb_arbiter

---
 rtl/fp_wrb_arbiter_pkg.sv | 25 ++
 rtl/fp_wrb_arbiter_rr_pick2.sv | 35 +++
 rtl/fp_wrb_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/fp_wrb_arbiter_pkg.sv
// Shared RCU constants for the FP writeback path: data width, FP register
// file geometry and the fixed source indices feeding the writeback arbiter.
package fp_wrb_arbiter_pkg;

  localparam int XLEN           = 64;
  localparam int FP_REGS        = 64;
  localparam int REG_SIZE_WIDTH = $clog2(FP_REGS);
  localparam int NUM_SRC        = 4;

  localparam int SRC_FALU1    = 0;
  localparam int SRC_FALU2    = 1;
  localparam int SRC_LSU      = 2;
  localparam int SRC_FDIVSQRT = 3;

  // Index of the set bit in a one-hot (or zero) 4-bit vector.
  function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/fp_wrb_arbiter_rr_pick2.sv
// Round-robin selector that picks the first two requesters found when
// scanning upward (with wrap) from ptr_i. Purely combinational.
module rr_pick2 (
  input  logic [3:0] req_i,
  input  logic [1:0] ptr_i,
  output logic [3:0] gnt0_o,
  output logic [3:0] gnt1_o
);

  logic [1:0] idx;
  logic       found0;
  logic       found1;

  // Walk the four positions starting at the pointer; first hit -> gnt0, second -> gnt1.
  always_comb begin
    gnt0_o = 4'b0000;
    gnt1_o = 4'b0000;
    found0 = 1'b0;
    found1 = 1'b0;
    idx    = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_i + 2'(i);
      if (req_i[idx]) begin
        if (!found0) begin
          gnt0_o[idx] = 1'b1;
          found0      = 1'b1;
        end else if (!found1) begin
          gnt1_o[idx] = 1'b1;
          found1      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fp_wrb_arbiter.sv
// FP writeback arbiter: four result sources, one holding slot each, drained
// onto the two FP regfile write ports in round-robin order. Write ports are
// driven from registered slot state only, so a result accepted at an edge is
// written no earlier than the following cycle.
//
// Handshake: a source transfers on a rising edge when src_valid_i[k] and
// src_ready_o[k] are both high; ready means the slot is empty or is being
// drained this cycle, and is forced low during rst and flush_i.
module fp_wrb_arbiter #(
  parameter int REG_SIZE_WIDTH = fp_wrb_arbiter_pkg::REG_SIZE_WIDTH,
  parameter int XLEN           = fp_wrb_arbiter_pkg::XLEN
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush_i,
  input  logic [3:0]                src_valid_i,
  input  logic [REG_SIZE_WIDTH-1:0] src_address_i [4],
  input  logic [XLEN-1:0]           src_data_i [4],
  output logic [3:0]                src_ready_o,
  output logic                      wr_first_valid_o,
  output logic [REG_SIZE_WIDTH-1:0] wr_first_address_o,
  output logic [XLEN-1:0]           wr_first_data_o,
  output logic                      wr_second_valid_o,
  output logic [REG_SIZE_WIDTH-1:0] wr_second_address_o,
  output logic [XLEN-1:0]           wr_second_data_o,
  output logic [2:0]                pending_cnt_o,
  output logic [1:0]                rr_ptr_o
);

  import fp_wrb_arbiter_pkg::*;

  logic [3:0]                slot_v_q, slot_v_d;
  logic [REG_SIZE_WIDTH-1:0] slot_a_q [4];
  logic [REG_SIZE_WIDTH-1:0] slot_a_d [4];
  logic [XLEN-1:0]           slot_d_q [4];
  logic [XLEN-1:0]           slot_d_d [4];
  logic [1:0]                rr_ptr_q, rr_ptr_d;

  logic [3:0] pick0, pick1, gnt;
  logic [1:0] idx0, idx1;
  logic       gnt0_v, gnt1_v;

  rr_pick2 u_pick (
    .req_i  (slot_v_q),
    .ptr_i  (rr_ptr_q),
    .gnt0_o (pick0),
    .gnt1_o (pick1)
  );

  // Qualify picks: nothing is written in reset, and a second candidate that
  // targets the same register as the first waits for a later cycle.
  always_comb begin
    idx0   = onehot_to_idx(pick0);
    idx1   = onehot_to_idx(pick1);
    gnt0_v = (|pick0) && !rst;
    gnt1_v = (|pick1) && !rst && (slot_a_q[idx1] != slot_a_q[idx0]);
    gnt    = (gnt0_v ? pick0 : 4'b0000) | (gnt1_v ? pick1 : 4'b0000);
  end

  // Write-port drive; register 0 is hard-wired zero so its data is forced to 0.
  always_comb begin
    wr_first_valid_o    = gnt0_v;
    wr_first_address_o  = gnt0_v ? slot_a_q[idx0] : '0;
    wr_first_data_o     = (gnt0_v && slot_a_q[idx0] != '0) ? slot_d_q[idx0] : '0;
    wr_second_valid_o   = gnt1_v;
    wr_second_address_o = gnt1_v ? slot_a_q[idx1] : '0;
    wr_second_data_o    = (gnt1_v && slot_a_q[idx1] != '0) ? slot_d_q[idx1] : '0;
  end

  // Ready, slot next-state and pointer advance.
  always_comb begin
    slot_v_d = slot_v_q;
    rr_ptr_d = rr_ptr_q;
    for (int k = 0; k < NUM_SRC; k++) begin
      slot_a_d[k]    = slot_a_q[k];
      slot_d_d[k]    = slot_d_q[k];
      src_ready_o[k] = !rst && !flush_i && (!slot_v_q[k] || gnt[k]);
      if (rst || flush_i) begin
        slot_v_d[k] = 1'b0;
      end else if (src_valid_i[k] && src_ready_o[k]) begin
        slot_v_d[k] = 1'b1;
        slot_a_d[k] = src_address_i[k];
        slot_d_d[k] = src_data_i[k];
      end else if (gnt[k]) begin
        slot_v_d[k] = 1'b0;
      end
    end
    if (rst)         rr_ptr_d = 2'd0;
    else if (gnt1_v) rr_ptr_d = idx1 + 2'd1;
    else if (gnt0_v) rr_ptr_d = idx0 + 2'd1;
  end

  // Occupancy count from registered state only.
  always_comb begin
    pending_cnt_o = 3'd0;
    for (int k = 0; k < NUM_SRC; k++) begin
      pending_cnt_o = pending_cnt_o + 3'(slot_v_q[k]);
    end
    rr_ptr_o = rr_ptr_q;
  end

  // State registers; reset is folded into the _d logic (synchronous).
  always_ff @(posedge clk) begin
    slot_v_q <= slot_v_d;
    rr_ptr_q <= rr_ptr_d;
    for (int k = 0; k < NUM_SRC; k++) begin
      slot_a_q[k] <= slot_a_d[k];
      slot_d_q[k] <= slot_d_d[k];
    end
  end

endmodule
